// File: rtl/uart_frame_dispatch.sv
// Parses checksummed 11-byte UART frames (EB 9C A[31:0] S D[23:0] K) and dispatches
// 24-bit delay words into N_CH per-channel RAM write ports with per-channel pointers.
module uart_frame_dispatch #(
  parameter int          N_CH     = 4,
  parameter int          ADDR_W   = 11,
  parameter logic [15:0] TIMEOUT  = 16'd50000,
  parameter logic [31:0] WR_ADDR  = 32'h02002000,
  parameter logic [31:0] CLR_ADDR = 32'h02002004,
  parameter bit          BCAST_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_byte,
  input  logic                     i_byte_vld,
  input  logic [3:0]               i_slot,
  output logic [N_CH-1:0]          o_wea,
  output logic [N_CH*ADDR_W-1:0]   o_waddr,
  output logic [N_CH*24-1:0]       o_wdata,
  output logic                     o_frame_ok,
  output logic                     o_csum_err,
  output logic                     o_tmo_err,
  output logic [15:0]              o_err_cnt,
  output logic [N_CH-1:0]          o_ovf
);

  typedef enum logic [2:0] {
    HDR1  = 3'd0,
    HDR2  = 3'd1,
    PAY   = 3'd2,
    CSUM  = 3'd3,
    CHECK = 3'd4
  } state_t;

  // Sum of the two header bytes EB + 9C, modulo 256.
  localparam logic [7:0] SUM_SEED = 8'h87;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t                  state_r, state_nx_s;
  logic [2:0]              idx_r;
  logic [63:0]             pay_r;
  logic [7:0]              sum_r;
  logic [15:0]             idle_r;
  logic [ADDR_W-1:0]       ptr_r [N_CH];
  logic [N_CH-1:0]         wea_r, ovf_r;
  logic [N_CH*ADDR_W-1:0]  waddr_r;
  logic [N_CH*24-1:0]      wdata_r;
  logic                    frame_ok_r, csum_err_r, tmo_err_r;
  logic [15:0]             err_cnt_r;

  logic        idle_hit_s, in_frame_s, tmo_s, in_check_s, sum_ok_s;
  logic        slot_hit_s, ch_ok_s, do_wr_s, do_clr_s, csum_bad_s;
  logic [31:0] addr_s;
  logic [3:0]  slot_s, ch_s;
  logic [23:0] data_s;

  assign idle_hit_s = (idle_r == (TIMEOUT - 16'd1));
  assign in_frame_s = (state_r == HDR2) || (state_r == PAY) || (state_r == CSUM);
  assign in_check_s = (state_r == CHECK);
  assign sum_ok_s   = (sum_r == 8'h00);
  assign addr_s     = pay_r[63:32];
  assign slot_s     = pay_r[31:28];
  assign ch_s       = pay_r[27:24];
  assign data_s     = pay_r[23:0];
  assign slot_hit_s = (slot_s == i_slot) || (BCAST_EN && (slot_s == 4'hF));
  assign ch_ok_s    = ({1'b0, ch_s} < 5'(N_CH));
  assign csum_bad_s = in_check_s && !sum_ok_s;
  assign do_wr_s    = in_check_s && sum_ok_s && slot_hit_s && ch_ok_s && (addr_s == WR_ADDR);
  assign do_clr_s   = in_check_s && sum_ok_s && slot_hit_s && ch_ok_s && (addr_s == CLR_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= HDR1;
    else     state_r <= state_nx_s;
  end

  // Next-state decode; an expiring idle counter aborts the partial frame.
  always_comb begin
    state_nx_s = state_r;
    tmo_s      = 1'b0;
    case (state_r)
      HDR1, CHECK: begin
        if (i_byte_vld && (i_byte == 8'hEB)) state_nx_s = HDR2;
        else                                 state_nx_s = HDR1;
      end
      HDR2: begin
        if (i_byte_vld) begin
          if (i_byte == 8'h9C)      state_nx_s = PAY;
          else if (i_byte == 8'hEB) state_nx_s = HDR2;
          else                      state_nx_s = HDR1;
        end else if (idle_hit_s) begin
          tmo_s      = 1'b1;
          state_nx_s = HDR1;
        end else begin
          state_nx_s = HDR2;
        end
      end
      PAY: begin
        if (i_byte_vld) begin
          if (idx_r == 3'd7) state_nx_s = CSUM;
          else               state_nx_s = PAY;
        end else if (idle_hit_s) begin
          tmo_s      = 1'b1;
          state_nx_s = HDR1;
        end else begin
          state_nx_s = PAY;
        end
      end
      CSUM: begin
        if (i_byte_vld) begin
          state_nx_s = CHECK;
        end else if (idle_hit_s) begin
          tmo_s      = 1'b1;
          state_nx_s = HDR1;
        end else begin
          state_nx_s = CSUM;
        end
      end
      default: state_nx_s = HDR1;
    endcase
  end

  // Frame capture, checksum, error reporting and per-channel RAM write ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r      <= 3'd0;
      pay_r      <= 64'd0;
      sum_r      <= 8'd0;
      idle_r     <= 16'd0;
      wea_r      <= '0;
      ovf_r      <= '0;
      waddr_r    <= '0;
      wdata_r    <= '0;
      frame_ok_r <= 1'b0;
      csum_err_r <= 1'b0;
      tmo_err_r  <= 1'b0;
      err_cnt_r  <= 16'd0;
      for (int k = 0; k < N_CH; k++) ptr_r[k] <= '0;
    end else begin
      wea_r      <= '0;
      frame_ok_r <= in_check_s && sum_ok_s;
      csum_err_r <= csum_bad_s;
      tmo_err_r  <= tmo_s;
      if ((csum_bad_s || tmo_s) && (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'd1;

      if (in_frame_s && !i_byte_vld && !tmo_s) idle_r <= idle_r + 16'd1;
      else                                     idle_r <= 16'd0;

      case (state_r)
        HDR2: begin
          if (i_byte_vld && (i_byte == 8'h9C)) begin
            sum_r <= SUM_SEED;
            idx_r <= 3'd0;
          end
        end
        PAY: begin
          if (i_byte_vld) begin
            pay_r <= {pay_r[55:0], i_byte};
            sum_r <= sum8(sum_r, i_byte);
            idx_r <= idx_r + 3'd1;
          end
        end
        CSUM: begin
          if (i_byte_vld) sum_r <= sum8(sum_r, i_byte);
        end
        default: ;
      endcase

      for (int k = 0; k < N_CH; k++) begin
        if (ch_s == 4'(k)) begin
          if (do_wr_s) begin
            wea_r[k]                     <= 1'b1;
            waddr_r[k*ADDR_W +: ADDR_W]  <= ptr_r[k];
            wdata_r[k*24 +: 24]          <= data_s;
            ptr_r[k]                     <= ptr_r[k] + 1'b1;
            if (&ptr_r[k]) ovf_r[k] <= 1'b1;
          end else if (do_clr_s) begin
            ptr_r[k] <= '0;
            ovf_r[k] <= 1'b0;
          end
        end
      end
    end
  end

  assign o_wea      = wea_r;
  assign o_waddr    = waddr_r;
  assign o_wdata    = wdata_r;
  assign o_frame_ok = frame_ok_r;
  assign o_csum_err = csum_err_r;
  assign o_tmo_err  = tmo_err_r;
  assign o_err_cnt  = err_cnt_r;
  assign o_ovf      = ovf_r;

endmodule

// File: tb/tb_uart_frame_dispatch.sv
// Directed bench for uart_frame_dispatch: small ADDR_W and TIMEOUT so wrap and
// timeout behaviour is reachable quickly; each comparison is an immediate assertion.
module tb_uart_frame_dispatch;
  localparam int          N_CH    = 4;
  localparam int          ADDR_W  = 2;
  localparam logic [15:0] TMO     = 16'd20;
  localparam logic [31:0] WR_A    = 32'h02002000;
  localparam logic [31:0] CLR_A   = 32'h02002004;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [7:0]             i_byte;
  logic                   i_byte_vld;
  logic [3:0]             i_slot;
  logic [N_CH-1:0]        o_wea;
  logic [N_CH*ADDR_W-1:0] o_waddr;
  logic [N_CH*24-1:0]     o_wdata;
  logic                   o_frame_ok, o_csum_err, o_tmo_err;
  logic [15:0]            o_err_cnt;
  logic [N_CH-1:0]        o_ovf;

  int checks   = 0;
  int failures = 0;

  uart_frame_dispatch #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .TIMEOUT(TMO),
    .WR_ADDR(WR_A), .CLR_ADDR(CLR_A), .BCAST_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_vld(i_byte_vld), .i_slot(i_slot),
    .o_wea(o_wea), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_frame_ok(o_frame_ok),
    .o_csum_err(o_csum_err), .o_tmo_err(o_tmo_err), .o_err_cnt(o_err_cnt), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte: valid for exactly one rising edge, then 'gap' idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    i_byte     = b;
    i_byte_vld = 1'b1;
    @(negedge clk);
    i_byte_vld = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Sends the first 'cut' bytes of a frame; 'gap5' idle cycles follow the 5th byte.
  task automatic send_frame(input logic [31:0] a, input logic [3:0] s, input logic [3:0] c,
                            input logic [23:0] d, input logic [7:0] kadj,
                            input int cut, input int gap5);
    logic [7:0] fb [11];
    logic [7:0] sum;
    fb[0] = 8'hEB; fb[1] = 8'h9C;
    fb[2] = a[31:24]; fb[3] = a[23:16]; fb[4] = a[15:8]; fb[5] = a[7:0];
    fb[6] = {s, c};
    fb[7] = d[23:16]; fb[8] = d[15:8]; fb[9] = d[7:0];
    sum = 8'h00;
    for (int i = 0; i < 10; i++) sum = sum + fb[i];
    fb[10] = (8'h00 - sum) + kadj;
    for (int i = 0; i < cut; i++) send_byte(fb[i], (i == 4) ? gap5 : 0);
  endtask

  // Checks the pulses one cycle after CHECK, then that they lasted one cycle only.
  task automatic post_check(input string tag, input logic [3:0] wea, input logic ok,
                            input logic cerr);
    @(negedge clk);
    chk({tag, "_wea"}, 64'(o_wea), 64'(wea));
    chk({tag, "_ok"}, 64'(o_frame_ok), 64'(ok));
    chk({tag, "_cerr"}, 64'(o_csum_err), 64'(cerr));
    @(negedge clk);
    chk({tag, "_wea_1cyc"}, 64'(o_wea), 64'd0);
    chk({tag, "_ok_1cyc"}, 64'(o_frame_ok | o_csum_err), 64'd0);
  endtask

  function automatic logic [1:0] wa(input int k);
    return o_waddr[k*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [23:0] wd(input int k);
    return o_wdata[k*24 +: 24];
  endfunction

  initial begin
    rst = 1'b1; i_byte = 8'h00; i_byte_vld = 1'b0; i_slot = 4'd3;
    repeat (3) @(negedge clk);
    chk("rst_wea", 64'(o_wea), 64'd0);
    chk("rst_waddr", 64'(o_waddr), 64'd0);
    chk("rst_wdata", 64'(o_wdata), 64'd0);
    chk("rst_flags", 64'({o_frame_ok, o_csum_err, o_tmo_err}), 64'd0);
    chk("rst_errcnt", 64'(o_err_cnt), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1: good write to ch2
    send_frame(WR_A, 4'd3, 4'd2, 24'h123456, 8'h00, 11, 0);
    post_check("t1", 4'b0100, 1'b1, 1'b0);
    chk("t1_waddr2", 64'(wa(2)), 64'd0);
    chk("t1_wdata2", 64'(wd(2)), 64'h123456);

    // T2: bad checksum, then prove the pointer did not move
    send_frame(WR_A, 4'd3, 4'd2, 24'h123456, 8'h01, 11, 0);
    post_check("t2", 4'b0000, 1'b0, 1'b1);
    chk("t2_errcnt", 64'(o_err_cnt), 64'd1);
    chk("t2_wdata_hold", 64'(wd(2)), 64'h123456);
    send_frame(WR_A, 4'd3, 4'd2, 24'hABCDEF, 8'h00, 11, 0);
    post_check("t2b", 4'b0100, 1'b1, 1'b0);
    chk("t2b_waddr2", 64'(wa(2)), 64'd1);
    chk("t2b_wdata2", 64'(wd(2)), 64'hABCDEF);

    // T3: garbage then repeated EB before the header
    send_byte(8'h00, 0); send_byte(8'h11, 0); send_byte(8'hEB, 0);
    send_frame(WR_A, 4'd3, 4'd1, 24'h000777, 8'h00, 11, 0);
    post_check("t3", 4'b0010, 1'b1, 1'b0);
    chk("t3_waddr1", 64'(wa(1)), 64'd0);
    chk("t3_wdata1", 64'(wd(1)), 64'h000777);

    // T4: abort after TIMEOUT idle cycles; TIMEOUT-1 is still tolerated
    send_frame(WR_A, 4'd3, 4'd0, 24'h000001, 8'h00, 5, 0);
    repeat (int'(TMO) - 1) @(negedge clk);
    chk("t4_tmo_early", 64'(o_tmo_err), 64'd0);
    @(negedge clk);
    chk("t4_tmo", 64'(o_tmo_err), 64'd1);
    chk("t4_wea", 64'(o_wea), 64'd0);
    @(negedge clk);
    chk("t4_tmo_1cyc", 64'(o_tmo_err), 64'd0);
    chk("t4_errcnt", 64'(o_err_cnt), 64'd2);
    send_frame(WR_A, 4'd3, 4'd0, 24'h000001, 8'h00, 11, int'(TMO) - 1);
    chk("t4_no_tmo", 64'(o_tmo_err), 64'd0);
    post_check("t4b", 4'b0001, 1'b1, 1'b0);
    chk("t4b_waddr0", 64'(wa(0)), 64'd0);

    // T5: ch0 walks 1,2,3 then wraps to 0 with sticky overflow
    for (int n = 1; n <= 4; n++) begin
      send_frame(WR_A, 4'd3, 4'd0, 24'(n + 16), 8'h00, 11, 0);
      post_check("t5", 4'b0001, 1'b1, 1'b0);
      chk("t5_waddr0", 64'(wa(0)), 64'(n % 4));
      chk("t5_wdata0", 64'(wd(0)), 64'(n + 16));
      chk("t5_ovf", 64'(o_ovf), (n >= 3) ? 64'd1 : 64'd0);
    end
    send_frame(CLR_A, 4'd3, 4'd0, 24'h000000, 8'h00, 11, 0);
    post_check("t5_clr", 4'b0000, 1'b1, 1'b0);
    chk("t5_clr_ovf", 64'(o_ovf), 64'd0);
    send_frame(WR_A, 4'd3, 4'd0, 24'h00BEEF, 8'h00, 11, 0);
    post_check("t5_after_clr", 4'b0001, 1'b1, 1'b0);
    chk("t5_after_clr_waddr0", 64'(wa(0)), 64'd0);

    // T6: broadcast accepted; foreign slot, bad channel, unknown address ignored
    send_frame(WR_A, 4'hF, 4'd1, 24'h0F0F0F, 8'h00, 11, 0);
    post_check("t6_bcast", 4'b0010, 1'b1, 1'b0);
    chk("t6_bcast_waddr1", 64'(wa(1)), 64'd1);
    send_frame(WR_A, 4'd5, 4'd1, 24'h111111, 8'h00, 11, 0);
    post_check("t6_slot", 4'b0000, 1'b1, 1'b0);
    send_frame(WR_A, 4'd3, 4'd4, 24'h222222, 8'h00, 11, 0);
    post_check("t6_ch", 4'b0000, 1'b1, 1'b0);
    send_frame(32'h02002008, 4'd3, 4'd1, 24'h333333, 8'h00, 11, 0);
    post_check("t6_addr", 4'b0000, 1'b1, 1'b0);
    chk("t6_wdata1_hold", 64'(wd(1)), 64'h0F0F0F);
    chk("t6_errcnt", 64'(o_err_cnt), 64'd2);

    // Reset mid-frame drops the frame and clears pointers
    send_frame(WR_A, 4'd3, 4'd2, 24'h444444, 8'h00, 7, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h00, 3);
    chk("rstm_wea", 64'(o_wea), 64'd0);
    chk("rstm_errcnt", 64'(o_err_cnt), 64'd0);
    send_frame(WR_A, 4'd3, 4'd2, 24'h555555, 8'h00, 11, 0);
    post_check("rstm", 4'b0100, 1'b1, 1'b0);
    chk("rstm_waddr2", 64'(wa(2)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
